// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter in front of a single-port
// 32-bit RAM with a bidirectional data bus.
//
// Ports
//   CLK, RST               clock, synchronous active-high reset
//   REQ0/REQ1              access request per requester (held until GNTn)
//   WE0/WE1                1 = write, 0 = read
//   ADDR0/ADDR1            word address per requester
//   WDATA0/WDATA1          write data per requester
//   GNT0/GNT1              one-cycle pulse: request accepted
//   RVALID0/RVALID1        one-cycle pulse: RDATA holds this requester's read
//   RDATA                  shared read data, held between reads
//   MEM_CS/MEM_WE/MEM_ADDR RAM control and address
//   MEM_DATA               shared RAM data bus, driven here only during WR
//
// Access timing (GNT appears in the first cycle of the access):
//   write: WR, IDLE                       -> one write every 2 cycles
//   read : RD_ISSUE, RD_DATA, IDLE+RVALID -> one read every 3 cycles
module ram_arbiter #(
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [31:0]       WDATA0,
    input  logic [31:0]       WDATA1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              RVALID0,
    output logic              RVALID1,
    output logic [31:0]       RDATA,
    output logic              MEM_CS,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    inout  wire  [31:0]       MEM_DATA
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DATA  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                pri_q;     // requester that wins a tie
    logic                owner_q;   // requester being served
    logic [DATA_W-1:0]   wdata_q;
    logic                win_vld;
    logic                win_sel;
    logic                win_we;
    logic                grant;
    logic                bus_oe;

    // Winner selection: a lone request wins outright, a tie goes to pri_q.
    always_comb begin
        win_vld = REQ0 | REQ1;
        win_sel = (REQ0 && REQ1) ? pri_q : REQ1;
        win_we  = win_sel ? WE1 : WE0;
        grant   = (state_q == IDLE) && win_vld;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = win_we ? WR : RD_ISSUE;
                end
            end
            WR:       state_d = IDLE;
            RD_ISSUE: state_d = RD_DATA;
            RD_DATA:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output logic: RAM strobes decode directly from the state so the bus
    // direction changes on the same edge as the state, never overlapping
    // with the RAM driving during reads.
    always_comb begin
        MEM_CS = (state_q != IDLE);
        MEM_WE = (state_q == WR);
        bus_oe = (state_q == WR);
    end

    assign MEM_DATA = bus_oe ? wdata_q : {DATA_W{1'bz}};

    // Control registers: grant pulses, ownership, round-robin pointer,
    // address latch and read capture. Reset aborts any access in flight,
    // so a read caught in RD_ISSUE never produces RVALID.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pri_q    <= 1'b0;
            owner_q  <= 1'b0;
            GNT0     <= 1'b0;
            GNT1     <= 1'b0;
            RVALID0  <= 1'b0;
            RVALID1  <= 1'b0;
            RDATA    <= '0;
            MEM_ADDR <= '0;
        end else begin
            GNT0    <= grant && !win_sel;
            GNT1    <= grant &&  win_sel;
            RVALID0 <= (state_q == RD_DATA) && !owner_q;
            RVALID1 <= (state_q == RD_DATA) &&  owner_q;
            if (grant) begin
                owner_q  <= win_sel;
                pri_q    <= ~win_sel;
                MEM_ADDR <= win_sel ? ADDR1 : ADDR0;
            end
            if (state_q == RD_DATA) begin
                RDATA <= MEM_DATA;
            end
        end
    end

    // Write data latch; only meaningful while WR drives the bus.
    always_ff @(posedge CLK) begin
        if (grant) begin
            wdata_q <= win_sel ? WDATA1 : WDATA0;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus for ram_arbiter with a transaction-level
// reference model (per-access cycle timeline, shadow memory, round-robin
// pointer) compared against the DUT every cycle, plus literal expectations
// for the documented scenarios.
module tb_ram_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        REQ0, REQ1, WE0, WE1;
    logic [5:0]  ADDR0, ADDR1;
    logic [31:0] WDATA0, WDATA1;
    logic        GNT0, GNT1, RVALID0, RVALID1;
    logic [31:0] RDATA;
    logic        MEM_CS, MEM_WE;
    logic [5:0]  MEM_ADDR;
    wire  [31:0] MEM_DATA;

    int n_vec = 0;
    int n_bad = 0;

    ram_arbiter #(.ADDR_W(6)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .RVALID0(RVALID0), .RVALID1(RVALID1),
        .RDATA(RDATA), .MEM_CS(MEM_CS), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA)
    );

    always #5 CLK = ~CLK;

    // RAM attached to the bus: combinational read, write on the edge.
    logic [31:0] ram [0:63];
    assign MEM_DATA = (MEM_CS && !MEM_WE) ? ram[MEM_ADDR] : 32'bz;
    always @(posedge CLK) begin
        if (MEM_CS && MEM_WE) ram[MEM_ADDR] <= MEM_DATA;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          g0, g1, rv0, rv1, cs, we, has_addr, upd;
        logic [5:0]  addr;
        logic [31:0] bus;
        logic [31:0] rdata;
    } rec_t;

    rec_t        sched[$];
    rec_t        cur;
    logic [31:0] shadow [0:63];
    int          m_pri = 0;
    logic [5:0]  m_addr = '0;
    logic [31:0] m_rdata = '0;
    bit          armed = 1'b0;

    function automatic rec_t idle_rec();
        rec_t r;
        r.g0 = 0; r.g1 = 0; r.rv0 = 0; r.rv1 = 0; r.cs = 0; r.we = 0;
        r.has_addr = 0; r.upd = 0; r.addr = '0; r.bus = '0; r.rdata = '0;
        return r;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            armed   = 1'b1;
            sched.delete();
            m_pri   = 0;
            m_addr  = '0;
            m_rdata = '0;
            cur     = idle_rec();
        end else if (armed) begin
            if (sched.size() == 0) begin
                int w;
                w = -1;
                if (REQ0 && REQ1) w = m_pri;
                else if (REQ0)    w = 0;
                else if (REQ1)    w = 1;
                if (w >= 0) begin
                    rec_t r;
                    logic        we_w;
                    logic [5:0]  a_w;
                    logic [31:0] d_w;
                    we_w  = (w == 1) ? WE1 : WE0;
                    a_w   = (w == 1) ? ADDR1 : ADDR0;
                    d_w   = (w == 1) ? WDATA1 : WDATA0;
                    m_pri = 1 - w;
                    r = idle_rec();
                    r.g0 = (w == 0); r.g1 = (w == 1);
                    r.cs = 1; r.we = we_w; r.has_addr = 1; r.addr = a_w; r.bus = d_w;
                    sched.push_back(r);
                    if (we_w) begin
                        shadow[a_w] = d_w;
                        sched.push_back(idle_rec());
                    end else begin
                        r = idle_rec();
                        r.cs = 1;
                        sched.push_back(r);
                        r = idle_rec();
                        r.rv0 = (w == 0); r.rv1 = (w == 1);
                        r.upd = 1; r.rdata = shadow[a_w];
                        sched.push_back(r);
                    end
                end
            end
            if (sched.size() > 0) cur = sched.pop_front();
            else                  cur = idle_rec();
            if (cur.has_addr) m_addr = cur.addr;
            if (cur.upd)      m_rdata = cur.rdata;
        end
    end

    always @(negedge CLK) begin
        if (armed) begin
            chk("GNT0", GNT0, cur.g0);
            chk("GNT1", GNT1, cur.g1);
            chk("RVALID0", RVALID0, cur.rv0);
            chk("RVALID1", RVALID1, cur.rv1);
            chk("MEM_CS", MEM_CS, cur.cs);
            chk("MEM_WE", MEM_WE, cur.we);
            chk("MEM_ADDR", MEM_ADDR, m_addr);
            chk("RDATA", RDATA, m_rdata);
            if (cur.cs && cur.we) chk("MEM_DATA", MEM_DATA, cur.bus);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    // Raise a request, hold it until its grant appears, then drop it.
    // Returns in the grant cycle.
    task automatic access(input int n, input logic we, input logic [5:0] a, input logic [31:0] d);
        bit seen;
        seen = 0;
        if (n == 0) begin REQ0 = 1; WE0 = we; ADDR0 = a; WDATA0 = d; end
        else        begin REQ1 = 1; WE1 = we; ADDR1 = a; WDATA1 = d; end
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = (n == 0) ? GNT0 : GNT1;
        end
        if (n == 0) REQ0 = 0; else REQ1 = 0;
        chk("access_granted", {31'b0, seen}, 1);
    endtask

    typedef struct {
        logic we0; logic [5:0] a0; logic [31:0] d0;
        logic we1; logic [5:0] a1; logic [31:0] d1;
    } pair_t;

    pair_t pairs [4];
    int    alt_q[$];
    bit    p0, p1;

    initial begin
        for (int i = 0; i < 64; i++) begin ram[i] = '0; shadow[i] = '0; end
        RST = 1; REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
        repeat (3) step();
        chk("rst_gnt0", GNT0, 0);
        chk("rst_cs", MEM_CS, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_addr", MEM_ADDR, 0);

        // Write DEADBEEF to 5 on the first unreset edge, read it back via 1.
        RST = 0; REQ0 = 1; WE0 = 1; ADDR0 = 6'd5; WDATA0 = 32'hDEADBEEF;
        step();
        chk("w5_gnt0", GNT0, 1);
        chk("w5_cs", MEM_CS, 1);
        chk("w5_we", MEM_WE, 1);
        chk("w5_addr", MEM_ADDR, 5);
        chk("w5_bus", MEM_DATA, 32'hDEADBEEF);
        REQ0 = 0; REQ1 = 1; WE1 = 0; ADDR1 = 6'd5;
        step();
        chk("r5_idle_cs", MEM_CS, 0);
        chk("r5_addr_hold", MEM_ADDR, 5);
        step();
        chk("r5_gnt1", GNT1, 1);
        chk("r5_we", MEM_WE, 0);
        REQ1 = 0;
        step();
        chk("r5_rvalid_early", RVALID1, 0);
        step();
        chk("r5_rvalid1", RVALID1, 1);
        chk("r5_rdata", RDATA, 32'hDEADBEEF);

        // Top address write and read-back.
        access(0, 1, 6'd63, 32'h12345678);
        access(0, 0, 6'd63, 32'h0);
        step();
        step();
        chk("a63_rvalid0", RVALID0, 1);
        chk("a63_rdata", RDATA, 32'h12345678);

        // Both held continuously after reset: grants alternate 0,1,0,1.
        RST = 1;
        step();
        RST = 0;
        REQ0 = 1; WE0 = 1; ADDR0 = 6'd10; WDATA0 = 32'h000000A0;
        REQ1 = 1; WE1 = 1; ADDR1 = 6'd11; WDATA1 = 32'h000000B1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (GNT0) alt_q.push_back(0);
            if (GNT1) alt_q.push_back(1);
        end
        REQ0 = 0; REQ1 = 0;
        chk("alt_count", alt_q.size(), 4);
        for (int i = 0; i < 4 && i < alt_q.size(); i++)
            chk("alt_order", alt_q[i], i % 2);

        // Read by 0 in progress, request 1 raised during RD_ISSUE.
        REQ0 = 1; WE0 = 0; ADDR0 = 6'd10;
        step();
        chk("pend_gnt0", GNT0, 1);
        REQ0 = 0; REQ1 = 1; WE1 = 1; ADDR1 = 6'd20; WDATA1 = 32'hCAFEF00D;
        step();
        chk("pend_no_gnt1_a", GNT1, 0);
        step();
        chk("pend_rvalid0", RVALID0, 1);
        chk("pend_rdata", RDATA, 32'h000000A0);
        chk("pend_no_gnt1_b", GNT1, 0);
        step();
        chk("pend_gnt1", GNT1, 1);
        REQ1 = 0;

        // Request raised while busy and withdrawn before arbitration.
        REQ0 = 1; WE0 = 1; ADDR0 = 6'd30; WDATA0 = 32'h0BADF00D;
        step();
        REQ0 = 0;
        step();
        chk("wd_no_gnt0", GNT0, 0);
        chk("wd_cs", MEM_CS, 0);

        // Reset during RD_ISSUE aborts the read.
        REQ0 = 1; WE0 = 0; ADDR0 = 6'd20;
        step();
        chk("abort_gnt0", GNT0, 1);
        REQ0 = 0; RST = 1;
        step();
        chk("abort_gnt0_clr", GNT0, 0);
        chk("abort_cs", MEM_CS, 0);
        chk("abort_addr", MEM_ADDR, 0);
        chk("abort_rdata", RDATA, 0);
        RST = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_rvalid", RVALID0, 0);
        end

        // Concurrent mixed requests; the model decides the order.
        pairs[0] = '{1'b1, 6'd40, 32'h00000111, 1'b1, 6'd41, 32'h00000222};
        pairs[1] = '{1'b0, 6'd41, 32'h0,        1'b0, 6'd40, 32'h0};
        pairs[2] = '{1'b1, 6'd63, 32'h00000055, 1'b0, 6'd63, 32'h0};
        pairs[3] = '{1'b0, 6'd5,  32'h0,        1'b1, 6'd5,  32'h00000077};
        for (int k = 0; k < 4; k++) begin
            REQ0 = 1; WE0 = pairs[k].we0; ADDR0 = pairs[k].a0; WDATA0 = pairs[k].d0;
            REQ1 = 1; WE1 = pairs[k].we1; ADDR1 = pairs[k].a1; WDATA1 = pairs[k].d1;
            p0 = 1; p1 = 1;
            for (int c = 0; c < 30 && (p0 || p1); c++) begin
                step();
                if (GNT0) begin REQ0 = 0; p0 = 0; end
                if (GNT1) begin REQ1 = 0; p1 = 0; end
            end
            REQ0 = 0; REQ1 = 0;
            chk("burst_done", {30'b0, p0, p1}, 0);
        end
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, word-address width of the shared 32-bit RAM (64 words).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports REQ0/REQ1  input  1  access request from requester 0/1.
REQ-005 SHALL have ports WE0/WE1  input  1  request type per requester: 1 = write, 0 = read.
REQ-006 SHALL have ports ADDR0/ADDR1  input  ADDR_W  word address per requester.
REQ-007 SHALL have ports WDATA0/WDATA1  input  32  write data per requester.
REQ-008 SHALL have ports GNT0/GNT1  output  1  one-cycle pulse: request accepted.
REQ-009 SHALL have ports RVALID0/RVALID1  output  1  one-cycle pulse: RDATA holds read result.
REQ-010 SHALL have port RDATA  output  32  read data, shared by both requesters.
REQ-011 SHALL have port MEM_CS  output  1  RAM chip select.
REQ-012 SHALL have port MEM_WE  output  1  RAM write enable.
REQ-013 SHALL have port MEM_ADDR  output  ADDR_W  RAM address.
REQ-014 SHALL have port MEM_DATA  inout  32  shared RAM data bus; RAM drives it while CS=1 and WE=0.

Function
REQ-015 SHALL use FSM states IDLE, WR, RD_ISSUE, RD_DATA.
REQ-016 Requester SHALL hold REQn, WEn, ADDRn, WDATAn stable from assertion until its GNTn pulse; arbiter SHALL latch them when leaving IDLE.
REQ-017 IDLE: single REQ SHALL win; both asserted SHALL go to requester named by priority pointer PRI.
REQ-018 Leaving IDLE SHALL register winner's GNTn=1 for exactly the next cycle; go to WR if WEn=1, else RD_ISSUE.
REQ-019 After serving requester n, PRI SHALL point to the other requester (round-robin); PRI unchanged while idle.
REQ-020 WR (1 cycle): MEM_CS=1, MEM_WE=1, MEM_ADDR=latched addr, MEM_DATA driven with latched wdata; then IDLE.
REQ-021 RD_ISSUE (1 cycle): MEM_CS=1, MEM_WE=0, MEM_ADDR=latched addr; then RD_DATA.
REQ-022 RD_DATA (1 cycle): MEM_CS=1, MEM_WE=0, address held; RDATA<=MEM_DATA at end of cycle; RVALIDn=1 for the following cycle; then IDLE.
REQ-023 MEM_DATA SHALL be high-Z in every state except WR; no cycle with both sides driving.
REQ-024 IDLE: MEM_CS=0, MEM_WE=0; MEM_ADDR holds last value.
REQ-025 Latency: write GNT to RAM update 1 cycle; read GNT to RVALID 2 cycles; back-to-back service: write every 2 cycles, read every 3.
REQ-026 REQ asserted while busy SHALL be held pending, not lost; arbitrated at next IDLE.
REQ-027 REQn dropped before GNTn: request withdrawn, no access.
REQ-028 GNT0/GNT1 and RVALID0/RVALID1 SHALL never be high simultaneously; RDATA holds value between reads.
REQ-029 Address range full ADDR_W; no wrap or bounds logic.

Reset
REQ-030 RST=1 at an edge: state=IDLE, PRI=0, GNTn=0, RVALIDn=0, RDATA=0, MEM_CS=0, MEM_WE=0, MEM_ADDR=0, MEM_DATA high-Z.
REQ-031 RST mid-operation SHALL abort: no RVALID from an aborted read, no further write cycle.
REQ-032 First arbitration SHALL occur on the first edge with RST=0.

Verification
REQ-033 REQ0=1, WE0=1, ADDR0=5, WDATA0=0xDEADBEEF -> GNT0 next cycle; WR cycle CS=1, WE=1, ADDR=5, bus=0xDEADBEEF.
REQ-034 Then REQ1=1, WE1=0, ADDR1=5 -> GNT1; RVALID1 2 cycles later, RDATA=0xDEADBEEF; bus high-Z except WR cycles.
REQ-035 REQ0 and REQ1 both held continuously (writes) -> grants alternate GNT0, GNT1, GNT0, ... after reset.
REQ-036 Read by 0 in progress, REQ1 asserted during RD_ISSUE -> REQ1 granted on first IDLE after RVALID0.
REQ-037 RST asserted during RD_ISSUE -> next cycle all outputs at reset values, RVALID never pulses.
REQ-038 Write 0x12345678 to ADDR=63, read back -> RDATA=0x12345678.
